// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: MEM-stage request/response and data-memory bus bundle
interface dmem_access_ctrl_if #(parameter int ADDR_WIDTH = 32);
  logic                  req_valid;
  logic                  req_read;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [2:0]            req_funct3;
  logic                  stall;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  err;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  modport master (
    output req_valid, req_read, req_write, req_addr, req_wdata, req_funct3, mem_rdata,
    input  stall, resp_valid, resp_rdata, err, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_read, req_write, req_addr, req_wdata, req_funct3, mem_rdata,
    output stall, resp_valid, resp_rdata, err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences loads, stores and sub-word read-modify-write on a single-port memory
module dmem_access_ctrl #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_WIDTH  = 32
) (
  input logic clk,
  input logic rst,
  dmem_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;
  state_t      state;
  logic [1:0]  lo;
  logic [31:0] wdata;
  logic [2:0]  f3;
  logic        is_wr;
  logic [1:0]  cnt;
  logic        req, bad;
  logic [4:0]  sh;
  logic [31:0] rsh, load_val, mask, merged;
  assign req = bus.req_valid & (bus.req_read | bus.req_write);
  assign bad = (bus.req_funct3[1:0] == 2'd3) | (bus.req_funct3 == 3'd6) |
               ((bus.req_funct3[1:0] == 2'd1) & bus.req_addr[0]) |
               ((bus.req_funct3[1:0] == 2'd2) & (|bus.req_addr[1:0]));
  assign bus.stall = (state == IDLE) ? req : (state != DONE);
  assign sh = {lo, 3'b000};
  assign rsh = bus.mem_rdata >> sh;
  // funct3[2] selects zero extension for BU/HU
  assign load_val = (f3[1:0] == 2'd0) ? {{24{~f3[2] & rsh[7]}}, rsh[7:0]} :
                    (f3[1:0] == 2'd1) ? {{16{~f3[2] & rsh[15]}}, rsh[15:0]} : bus.mem_rdata;
  assign mask = ((f3[1:0] == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
  assign merged = (bus.mem_rdata & ~mask) | ((wdata << sh) & mask);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lo <= '0;
      wdata <= '0;
      f3 <= '0;
      is_wr <= 1'b0;
      cnt <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.err <= 1'b0;
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.err <= 1'b0;
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: if (req) begin
          lo <= bus.req_addr[1:0];
          wdata <= bus.req_wdata;
          f3 <= bus.req_funct3;
          is_wr <= bus.req_write;
          bus.mem_addr <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
          if (bad) begin
            state <= DONE;
            bus.resp_valid <= 1'b1;
            bus.err <= 1'b1;
          end else if (bus.req_write && bus.req_funct3[1:0] == 2'd2) begin
            state <= WR;
            bus.mem_en <= 1'b1;
            bus.mem_we <= 1'b1;
            bus.mem_wdata <= bus.req_wdata;
          end else begin
            state <= RD;
            bus.mem_en <= 1'b1;
          end
        end
        RD: begin
          state <= RD_WAIT;
          cnt <= '0;
        end
        // read data is valid on the last wait cycle
        RD_WAIT: if (cnt == 2'(MEM_LATENCY - 1)) begin
          if (is_wr) begin
            state <= WR;
            bus.mem_en <= 1'b1;
            bus.mem_we <= 1'b1;
            bus.mem_wdata <= merged;
          end else begin
            state <= DONE;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= load_val;
          end
        end else cnt <= cnt + 2'd1;
        WR: begin
          state <= DONE;
          bus.resp_valid <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench for dmem_access_ctrl at latency 1 and 3
module tb_dmem_access_ctrl;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_access_ctrl_if #(.ADDR_WIDTH(32)) b0 ();
  dmem_access_ctrl_if #(.ADDR_WIDTH(32)) b1 ();
  dmem_access_ctrl #(.MEM_LATENCY(1), .ADDR_WIDTH(32)) u0 (.clk(clk), .rst(rst), .bus(b0));
  dmem_access_ctrl #(.MEM_LATENCY(3), .ADDR_WIDTH(32)) u1 (.clk(clk), .rst(rst), .bus(b1));

  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  logic [31:0] p0, p1;
  always @(posedge clk) begin
    if (b0.mem_en && b0.mem_we) mem0[b0.mem_addr[7:2]] <= b0.mem_wdata;
    b0.mem_rdata <= mem0[b0.mem_addr[7:2]];
    if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[7:2]] <= b1.mem_wdata;
    p0 <= mem1[b1.mem_addr[7:2]];
    p1 <= p0;
    b1.mem_rdata <= p1;
  end

  logic [1:0] rv, st, men, mwe, er;
  logic [31:0] rd [2];
  logic [31:0] ma [2];
  logic [31:0] mwd [2];
  assign rv = {b1.resp_valid, b0.resp_valid};
  assign st = {b1.stall, b0.stall};
  assign men = {b1.mem_en, b0.mem_en};
  assign mwe = {b1.mem_we, b0.mem_we};
  assign er = {b1.err, b0.err};
  assign rd[0] = b0.resp_rdata;
  assign rd[1] = b1.resp_rdata;
  assign ma[0] = b0.mem_addr;
  assign ma[1] = b1.mem_addr;
  assign mwd[0] = b0.mem_wdata;
  assign mwd[1] = b1.mem_wdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          reads;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  exp_t rq [2][$];
  wr_t  wq [2][$];
  int stall_cnt [2];
  int rd_cnt [2];
  int t_iss [2];
  exp_t me;
  wr_t  mw;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (st[d]) stall_cnt[d]++;
      if (men[d] && !mwe[d]) rd_cnt[d]++;
      if (men[d] && mwe[d]) begin
        if (wq[d].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write dut%0d: addr %h data %h", d, ma[d], mwd[d]);
        end else begin
          mw = wq[d].pop_front();
          chk($sformatf("waddr dut%0d", d), ma[d], mw.addr);
          chk($sformatf("wdata dut%0d", d), mwd[d], mw.data);
        end
      end
      if (rv[d]) begin
        if (rq[d].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp dut%0d: rdata %h", d, rd[d]);
        end else begin
          me = rq[d].pop_front();
          chk($sformatf("rdata dut%0d", d), rd[d], me.rdata);
          chk($sformatf("err dut%0d", d), 32'(er[d]), 32'(me.err));
          chk($sformatf("latency dut%0d", d), 32'(cyc - t_iss[d]), 32'(me.lat));
          chk($sformatf("reads dut%0d", d), 32'(rd_cnt[d]), 32'(me.reads));
          chk($sformatf("stalls dut%0d", d), 32'(stall_cnt[d]), 32'(me.lat));
        end
      end
    end
  end

  task automatic drive(input int d, input logic v, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f);
    if (d == 0) begin
      b0.req_valid = v; b0.req_read = r; b0.req_write = w;
      b0.req_addr = a; b0.req_wdata = wd; b0.req_funct3 = f;
    end else begin
      b1.req_valid = v; b1.req_read = r; b1.req_write = w;
      b1.req_addr = a; b1.req_wdata = wd; b1.req_funct3 = f;
    end
  endtask

  task automatic issue(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat, input int reads,
                       input logic has_w, input logic [31:0] wa, input logic [31:0] wv);
    exp_t e;
    wr_t x;
    int n;
    e = '{exp_rd, exp_err, lat, reads};
    rq[d].push_back(e);
    if (has_w) begin
      x = '{wa, wv};
      wq[d].push_back(x);
    end
    stall_cnt[d] = 0;
    rd_cnt[d] = 0;
    t_iss[d] = cyc;
    drive(d, 1'b1, r, w, a, wd, f);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rv[d] && n < 30);
    if (!rv[d]) begin
      total++;
      bad++;
      $display("FAIL timeout dut%0d: no resp_valid after %0d cycles, required %0d", d, n, lat);
    end
    drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    for (int i = 0; i < 64; i++) begin
      mem0[i] <= 32'h0;
      mem1[i] <= 32'h0;
    end
    #1;
    mem0[4] <= 32'hDEADBEEF;
    mem0[8] <= 32'h11223344;
    mem1[8] <= 32'h11223344;
    repeat (2) @(posedge clk);
    #1;
    chk("rst stall", 32'(b0.stall), 32'h0);
    chk("rst resp_valid", 32'(b0.resp_valid), 32'h0);
    chk("rst err", 32'(b0.err), 32'h0);
    chk("rst mem_en_we", 32'({b0.mem_en, b0.mem_we}), 32'h0);
    chk("rst resp_rdata", b0.resp_rdata, 32'h0);
    chk("rst mem_addr", b0.mem_addr, 32'h0);
    chk("rst mem_wdata", b0.mem_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // loads at latency 1
    issue(0, 1, 0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 0, 3, 1, 0, 32'h0, 32'h0);
    mem0[4] <= 32'h80FF7F01;
    #1;
    issue(0, 1, 0, 32'h13, 32'h0, 3'd0, 32'hFFFFFF80, 0, 3, 1, 0, 32'h0, 32'h0);
    issue(0, 1, 0, 32'h13, 32'h0, 3'd4, 32'h00000080, 0, 3, 1, 0, 32'h0, 32'h0);
    issue(0, 1, 0, 32'h12, 32'h0, 3'd1, 32'hFFFF80FF, 0, 3, 1, 0, 32'h0, 32'h0);
    issue(0, 1, 0, 32'h12, 32'h0, 3'd5, 32'h000080FF, 0, 3, 1, 0, 32'h0, 32'h0);
    issue(0, 1, 0, 32'h10, 32'h0, 3'd0, 32'h00000001, 0, 3, 1, 0, 32'h0, 32'h0);
    // stores
    issue(0, 0, 1, 32'h21, 32'h000000AB, 3'd0, 32'h1, 0, 4, 1, 1, 32'h20, 32'h1122AB44);
    issue(0, 0, 1, 32'h22, 32'h1234BEEF, 3'd1, 32'h1, 0, 4, 1, 1, 32'h20, 32'hBEEFAB44);
    issue(0, 0, 1, 32'h30, 32'hCAFEF00D, 3'd2, 32'h1, 0, 2, 0, 1, 32'h30, 32'hCAFEF00D);
    issue(0, 1, 1, 32'h34, 32'h55AA55AA, 3'd2, 32'h1, 0, 2, 0, 1, 32'h34, 32'h55AA55AA);
    chk("mem word 0x20", mem0[8], 32'hBEEFAB44);
    // illegal and misaligned
    issue(0, 1, 0, 32'h42, 32'h0, 3'd2, 32'h1, 1, 1, 0, 0, 32'h0, 32'h0);
    issue(0, 0, 1, 32'h43, 32'hFFFF, 3'd1, 32'h1, 1, 1, 0, 0, 32'h0, 32'h0);
    issue(0, 1, 0, 32'h40, 32'h0, 3'd3, 32'h1, 1, 1, 0, 0, 32'h0, 32'h0);
    issue(0, 1, 0, 32'h40, 32'h0, 3'd6, 32'h1, 1, 1, 0, 0, 32'h0, 32'h0);
    issue(0, 0, 1, 32'h40, 32'h0, 3'd7, 32'h1, 1, 1, 0, 0, 32'h0, 32'h0);
    issue(0, 1, 0, 32'h30, 32'h0, 3'd2, 32'hCAFEF00D, 0, 3, 1, 0, 32'h0, 32'h0);
    // reset during RD_WAIT of a halfword store
    drive(0, 1'b1, 1'b0, 1'b1, 32'h22, 32'h00009999, 3'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst stall", 32'(b0.stall), 32'h0);
    chk("midrst mem_en", 32'(b0.mem_en), 32'h0);
    chk("midrst resp_rdata", b0.resp_rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst mem word", mem0[8], 32'hBEEFAB44);
    issue(0, 1, 0, 32'h20, 32'h0, 3'd2, 32'hBEEFAB44, 0, 3, 1, 0, 32'h0, 32'h0);
    // byte store at latency 3
    issue(1, 0, 1, 32'h21, 32'h000000AB, 3'd0, 32'h0, 0, 6, 1, 1, 32'h20, 32'h1122AB44);
    issue(1, 1, 0, 32'h20, 32'h0, 3'd1, 32'hFFFFAB44, 0, 5, 1, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("resp queue0 empty", 32'(rq[0].size()), 32'h0);
    chk("resp queue1 empty", 32'(rq[1].size()), 32'h0);
    chk("write queue0 empty", 32'(wq[0].size()), 32'h0);
    chk("write queue1 empty", 32'(wq[1].size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
